alu_cmd_sequencer: RTL and testbench

- Command-driven controller that sequences the team's 8-bit ALU-with-flags unit (ALU_S_Flags).
- Owns a small register file and a flags register.
- Accepts one command at a time over a valid/ready handshake, drives the ALU operand/control lines, captures result and flags, writes back, and returns a response over a second valid/ready handshake.
- Sits between the top-level I/O decoder and the ALU instance; the parent wires alu_* ports to the ALU.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_regfile.sv | 35 +++
 rtl/alu_cmd_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: datapath width, ALU op codes,
// flag layout and sequencer FSM states.
package alu_pkg;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned FLAGS_W = 4;

    // ALU control codes driven onto ALUControl
    localparam logic [OP_W-1:0] ALU_OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] ALU_OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] ALU_OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] ALU_OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] ALU_OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] ALU_OP_SHL  = 3'd5;
    localparam logic [OP_W-1:0] ALU_OP_SHR  = 3'd6;
    localparam logic [OP_W-1:0] ALU_OP_PASS = 3'd7;

    // Bit positions of each flag inside the 4-bit {C,V,N,Z} word
    localparam int unsigned FLG_C = 3;
    localparam int unsigned FLG_V = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_Z = 0;

    // Flags register payload; field order matches the {C,V,N,Z} bit layout
    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, one synchronous write port,
// cleared by the asynchronous reset.
module alu_regfile #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4,
    parameter int unsigned RAW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RAW-1:0]   ra_addr,
    output logic [WIDTH-1:0] ra_data_c,
    input  logic [RAW-1:0]   rb_addr,
    output logic [WIDTH-1:0] rb_data_c,
    input  logic             we,
    input  logic [RAW-1:0]   wa,
    input  logic [WIDTH-1:0] wd
);

    logic [WIDTH-1:0] mem [NREGS];

    // Storage: clear everything on reset, single write per cycle otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign ra_data_c = mem[ra_addr];
    assign rb_data_c = mem[rb_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-driven sequencer for the 8-bit ALU-with-flags unit. Accepts one command
// at a time, issues registered operands to the ALU, captures result and flags,
// writes back and returns a response. Commands are fully serialised.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned NREGS = 4,
    parameter int unsigned RAW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_ld,
    input  logic [2:0]       cmd_op,
    input  logic [2:0]       cmd_amt,
    input  logic [RAW-1:0]   cmd_rd,
    input  logic [RAW-1:0]   cmd_ra,
    input  logic [RAW-1:0]   cmd_rb,
    input  logic             cmd_imm_sel,
    input  logic [WIDTH-1:0] cmd_imm,
    input  logic             cmd_nowb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    output logic [2:0]       alu_amt,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             alu_n,
    input  logic             alu_z,
    output logic             busy
);

    import alu_pkg::*;

    seq_state_t       state;
    logic [RAW-1:0]   rd_q;
    logic             nowb_q;
    alu_flags_t       flags_q;
    logic [WIDTH-1:0] rdata_a_c;
    logic [WIDTH-1:0] rdata_b_c;
    logic             we_c;
    logic [RAW-1:0]   wa_c;
    logic [WIDTH-1:0] wd_c;
    logic             accept_c;

    assign accept_c  = (state == IDLE) && cmd_valid && cmd_ready;
    assign rsp_flags = flags_q;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .RAW   (RAW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_addr   (cmd_ra),
        .ra_data_c (rdata_a_c),
        .rb_addr   (cmd_rb),
        .rb_data_c (rdata_b_c),
        .we        (we_c),
        .wa        (wa_c),
        .wd        (wd_c)
    );

    // Write-back select: immediate load on accept, or ALU result at the end of EXEC
    always_comb begin
        we_c = 1'b0;
        wa_c = rd_q;
        wd_c = alu_res;
        if (accept_c && cmd_ld) begin
            we_c = 1'b1;
            wa_c = cmd_rd;
            wd_c = cmd_imm;
        end else if (state == EXEC && !nowb_q) begin
            we_c = 1'b1;
        end
    end

    // Sequencer FSM with registered handshake, response and ALU-issue outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rsp_data  <= '0;
            flags_q   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            alu_amt   <= '0;
            rd_q      <= '0;
            nowb_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_ld) begin
                            rsp_data  <= cmd_imm;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_a    <= rdata_a_c;
                            alu_b    <= cmd_imm_sel ? cmd_imm : rdata_b_c;
                            alu_ctrl <= cmd_op;
                            alu_amt  <= cmd_amt;
                            rd_q     <= cmd_rd;
                            nowb_q   <= cmd_nowb;
                            state    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_res;
                    flags_q   <= '{c: alu_c, v: alu_v, n: alu_n, z: alu_z};
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: models the ALU on the alu_* lines, runs a table of
// directed commands, backpressure and reset-in-flight sequences, then random commands
// checked against a register-file/flags reference model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_ld = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_amt = '0;
    logic [1:0] cmd_rd = '0;
    logic [1:0] cmd_ra = '0;
    logic [1:0] cmd_rb = '0;
    logic       cmd_imm_sel = 1'b0;
    logic [7:0] cmd_imm = '0;
    logic       cmd_nowb = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic [7:0] alu_a, alu_b, alu_res;
    logic [2:0] alu_ctrl, alu_amt;
    logic       alu_c, alu_v, alu_n, alu_z;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int last_acc = 0;

    logic [7:0] m_rf [4];
    logic [3:0] m_flags;

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [2:0] amt;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       imm_sel;
        logic [7:0] imm;
        logic       nowb;
        int         hold;
        logic       use_exp;
        logic [7:0] exp_data;
        logic [3:0] exp_flags;
        int         exp_gap;
    } vec_t;

    alu_cmd_sequencer #(.WIDTH(8), .NREGS(4), .RAW(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ld      (cmd_ld),
        .cmd_op      (cmd_op),
        .cmd_amt     (cmd_amt),
        .cmd_rd      (cmd_rd),
        .cmd_ra      (cmd_ra),
        .cmd_rb      (cmd_rb),
        .cmd_imm_sel (cmd_imm_sel),
        .cmd_imm     (cmd_imm),
        .cmd_nowb    (cmd_nowb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_flags   (rsp_flags),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_amt     (alu_amt),
        .alu_res     (alu_res),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns {C,V,N,Z,result}
    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op, input logic [2:0] amt);
        logic [8:0] s;
        logic [7:0] r;
        logic c, v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            ALU_OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                c = s[8];
                v = (a[7] == b[7]) && (s[7] != a[7]);
            end
            ALU_OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                c = s[8];
                v = (a[7] != b[7]) && (s[7] != a[7]);
            end
            ALU_OP_AND: s = {1'b0, a & b};
            ALU_OP_OR:  s = {1'b0, a | b};
            ALU_OP_XOR: s = {1'b0, a ^ b};
            ALU_OP_SHL: begin
                s = {1'b0, a} << amt;
                c = s[8];
            end
            ALU_OP_SHR: s = {1'b0, a >> amt};
            default:    s = {1'b0, b};
        endcase
        r = s[7:0];
        return {c, v, r[7], (r == 8'd0), r};
    endfunction

    assign {alu_c, alu_v, alu_n, alu_z, alu_res} = alu_f(alu_a, alu_b, alu_ctrl, alu_amt);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic ld, input logic [2:0] op, input logic [2:0] amt,
                                input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                                input logic sel, input logic [7:0] imm, input logic nowb,
                                input logic [7:0] ed, input logic [3:0] ef, input int gap);
        vec_t v;
        v.ld = ld; v.op = op; v.amt = amt; v.rd = rd; v.ra = ra; v.rb = rb;
        v.imm_sel = sel; v.imm = imm; v.nowb = nowb; v.hold = 0;
        v.use_exp = 1'b1; v.exp_data = ed; v.exp_flags = ef; v.exp_gap = gap;
        return v;
    endfunction

    // Issue one command from a negedge, follow it through response and handshake
    task automatic run_cmd(input vec_t v, input logic keep_valid);
        logic [7:0]  a_e, b_e, d_e;
        logic [3:0]  f_e;
        logic [11:0] r;
        int n, acc;
        cmd_ld = v.ld; cmd_op = v.op; cmd_amt = v.amt; cmd_rd = v.rd; cmd_ra = v.ra;
        cmd_rb = v.rb; cmd_imm_sel = v.imm_sel; cmd_imm = v.imm; cmd_nowb = v.nowb;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (v.exp_gap > 0) chk("accept_gap", 32'(acc - last_acc), 32'(v.exp_gap));
        last_acc = acc;

        a_e = m_rf[v.ra];
        b_e = v.imm_sel ? v.imm : m_rf[v.rb];
        if (v.ld) begin
            d_e = v.imm;
            f_e = m_flags;
            m_rf[v.rd] = v.imm;
        end else begin
            r = alu_f(a_e, b_e, v.op, v.amt);
            d_e = r[7:0];
            f_e = r[11:8];
            m_flags = f_e;
            if (!v.nowb) m_rf[v.rd] = d_e;
        end
        if (v.use_exp) begin
            d_e = v.exp_data;
            f_e = v.exp_flags;
        end

        rsp_ready = (v.hold == 0);
        @(negedge clk);
        if (!keep_valid) cmd_valid = 1'b0;
        if (!v.ld) begin
            chk("alu_a", 32'(alu_a), 32'(a_e));
            chk("alu_b", 32'(alu_b), 32'(b_e));
            chk("alu_ctrl", 32'(alu_ctrl), 32'(v.op));
            chk("alu_amt", 32'(alu_amt), 32'(v.amt));
            chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("exec_busy", 32'(busy), 32'd1);
        end
        n = 1;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 32'(n), v.ld ? 32'd1 : 32'd2);
        chk("rsp_data", 32'(rsp_data), 32'(d_e));
        chk("rsp_flags", 32'(rsp_flags), 32'(f_e));
        chk("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(d_e));
            chk("hold_flags", 32'(rsp_flags), 32'(f_e));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        vec_t v;

        // Directed table: {cmd fields, expected rsp_data, expected {C,V,N,Z}, accept spacing}
        tbl[0] = mk(1'b1, ALU_OP_ADD, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h7F, 1'b0, 8'h7F, 4'b0000, 0);
        tbl[1] = mk(1'b1, ALU_OP_ADD, 3'd0, 2'd2, 2'd0, 2'd0, 1'b0, 8'h01, 1'b0, 8'h01, 4'b0000, 2);
        tbl[2] = mk(1'b0, ALU_OP_ADD, 3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 1'b0, 8'h80, 4'b0110, 2);
        tbl[3] = mk(1'b0, ALU_OP_SUB, 3'd0, 2'd3, 2'd1, 2'd0, 1'b1, 8'h7F, 1'b1, 8'h00, 4'b0001, 3);
        tbl[4] = mk(1'b0, ALU_OP_OR,  3'd0, 2'd3, 2'd3, 2'd0, 1'b1, 8'h00, 1'b0, 8'h80, 4'b0010, 3);
        tbl[5] = mk(1'b0, ALU_OP_ADD, 3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 1'b0, 8'h80, 4'b0110, 3);
        tbl[6] = mk(1'b0, ALU_OP_ADD, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 4'b1101, 3);
        tbl[7] = mk(1'b0, ALU_OP_SHL, 3'd3, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 1'b0, 8'hF8, 4'b1010, 3);
        tbl[8] = mk(1'b0, ALU_OP_SHR, 3'd3, 2'd2, 2'd1, 2'd0, 1'b0, 8'h00, 1'b0, 8'h1F, 4'b0000, 3);

        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_flags = 4'h0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_b", 32'(alu_b), 32'd0);
        chk("reset_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("reset_alu_amt", 32'(alu_amt), 32'd0);

        for (int i = 0; i < 9; i++) run_cmd(tbl[i], 1'b0);

        // Backpressure with cmd_valid held: second issue of the held command
        v = mk(1'b0, ALU_OP_ADD, 3'd0, 2'd3, 2'd2, 2'd2, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 3);
        v.use_exp = 1'b0;
        v.hold = 5;
        run_cmd(v, 1'b1);
        v.hold = 0;
        v.exp_gap = 8;
        run_cmd(v, 1'b0);

        // Reset while a command is in EXEC: no write-back, everything cleared
        cmd_ld = 1'b0; cmd_op = ALU_OP_ADD; cmd_amt = 3'd0; cmd_rd = 2'd0;
        cmd_ra = 2'd1; cmd_rb = 2'd2; cmd_imm_sel = 1'b0; cmd_nowb = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("exec_before_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_flags = 4'h0;
        @(negedge clk);
        chk("postreset_rsp_data", 32'(rsp_data), 32'd0);
        chk("postreset_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("postreset_cmd_ready", 32'(cmd_ready), 32'd1);
        v = mk(1'b0, ALU_OP_OR, 3'd0, 2'd0, 2'd0, 2'd1, 1'b0, 8'h00, 1'b1, 8'h00, 4'h0, 0);
        v.use_exp = 1'b0;
        run_cmd(v, 1'b0);
        v.ra = 2'd2;
        v.rb = 2'd3;
        run_cmd(v, 1'b0);

        // Random commands against the reference model
        for (int i = 0; i < 60; i++) begin
            v.ld      = ($urandom_range(0, 3) == 0);
            v.op      = 3'($urandom_range(0, 7));
            v.amt     = 3'($urandom_range(0, 7));
            v.rd      = 2'($urandom_range(0, 3));
            v.ra      = 2'($urandom_range(0, 3));
            v.rb      = 2'($urandom_range(0, 3));
            v.imm_sel = 1'($urandom_range(0, 1));
            v.imm     = 8'($urandom_range(0, 255));
            v.nowb    = ($urandom_range(0, 4) == 0);
            v.hold    = int'($urandom_range(0, 3));
            v.use_exp = 1'b0;
            v.exp_gap = 0;
            run_cmd(v, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
